// File: rtl/req_ack_responder.sv
// req_ack_responder: responder side of a four-phase req/ack handshake.
// After req is sampled high in IDLE, ack rises lat_cfg+1 edges later.
// ack is then held until req falls. If req drops before ack, a one-cycle
// err pulse is raised. Completed handshakes are counted in txn_cnt.
// Every output comes from a register.
// Optional build macro: REQ_ACK_RESPONDER_SVA_EN enables the embedded
// protocol assertions and a cover point; the logic is the same either way.
module req_ack_responder #(
  parameter int LAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [LAT_W-1:0] lat_cfg,
  output logic             ack,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] txn_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [LAT_W-1:0] r_cnt;
  logic [LAT_W-1:0] w_cnt_next;
  logic             r_ack;
  logic             w_ack_next;
  logic             r_busy;
  logic             w_busy_next;
  logic             r_err;
  logic             w_err_next;
  logic [CNT_W-1:0] r_txn_cnt;
  logic [CNT_W-1:0] w_txn_cnt_next;

  // State and output registers. Reset clears them at once, so ack and
  // busy drop mid-transaction without producing an err pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_txn_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_ack     <= w_ack_next;
      r_busy    <= w_busy_next;
      r_err     <= w_err_next;
      r_txn_cnt <= w_txn_cnt_next;
    end
  end

  // Next-state logic. ack, busy and err are computed one edge early so
  // that each output is a flop with no combinational path from req.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_ack_next     = r_ack;
    w_err_next     = 1'b0;
    w_txn_cnt_next = r_txn_cnt;
    unique case (r_state)
      ST_IDLE: begin
        w_ack_next = 1'b0;
        if (req) begin
          // lat_cfg is captured only here; later changes have no effect
          // on a transaction that has already started.
          w_cnt_next   = lat_cfg;
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_ack_next = 1'b0;
        if (!req) begin
          // An early drop has priority over the countdown, even when cnt==0.
          w_err_next   = 1'b1;
          w_state_next = ST_IDLE;
        end else if (r_cnt != '0) begin
          w_cnt_next = r_cnt - LAT_W'(1);
        end else begin
          w_ack_next   = 1'b1;
          w_state_next = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!req) begin
          w_ack_next     = 1'b0;
          w_txn_cnt_next = r_txn_cnt + CNT_W'(1);
          w_state_next   = ST_IDLE;
        end
      end
      default: begin
        w_ack_next   = 1'b0;
        w_state_next = ST_IDLE;
      end
    endcase
    w_busy_next = (w_state_next != ST_IDLE);
  end

  assign ack     = r_ack;
  assign busy    = r_busy;
  assign err     = r_err;
  assign txn_cnt = r_txn_cnt;

`ifdef REQ_ACK_RESPONDER_SVA_EN
  // Once req rises, it must stay high until ack rises.
  // An early drop, which also raises err, makes this property fail.
  a_req_until_ack: assert property (@(posedge clk) disable iff (rst)
    $rose(req) |-> (req until $rose(ack)));

  a_ack_after_req: assert property (@(posedge clk) disable iff (rst)
    $rose(ack) |-> $past(req));

  a_ack_drops: assert property (@(posedge clk) disable iff (rst)
    ($fell(req) && ack) |=> !ack);

  a_ack_busy: assert property (@(posedge clk) disable iff (rst)
    ack |-> busy);

  a_err_no_ack: assert property (@(posedge clk) disable iff (rst)
    err |-> !ack);

  c_lat_zero: cover property (@(posedge clk) disable iff (rst)
    (r_state == ST_IDLE && req && lat_cfg == '0) ##1 $rose(ack));
`endif

endmodule

// File: tb/tb_req_ack_responder.sv
// Directed bench for req_ack_responder. It runs the default instance
// (CNT_W=8) and a CNT_W=2 instance side by side from the same inputs.
module tb_req_ack_responder;

  logic       clk;
  logic       rst;
  logic       req;
  logic [3:0] lat_cfg;
  logic       ack;
  logic       busy;
  logic       err;
  logic [7:0] txn_cnt;
  logic       ack2;
  logic       busy2;
  logic       err2;
  logic [1:0] txn_cnt2;

  int n_cmp;
  int n_bad;
  int exp_cnt;

  int lat_tab[5]  = '{15, 0, 7, 1, 3};
  int cnt2_tab[5] = '{1, 2, 3, 0, 1};

  req_ack_responder #(.LAT_W(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .req(req), .lat_cfg(lat_cfg),
    .ack(ack), .busy(busy), .err(err), .txn_cnt(txn_cnt)
  );

  req_ack_responder #(.LAT_W(4), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .req(req), .lat_cfg(lat_cfg),
    .ack(ack2), .busy(busy2), .err(err2), .txn_cnt(txn_cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and move 1ns past the edge before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete handshake. req is first sampled high at the next edge (N).
  // ack must stay low through edge N+lat and go high at edge N+lat+1.
  // After that, req stays high for 'hold' more edges and then drops.
  task automatic run_txn(input int lat, input int hold);
    req     = 1'b1;
    lat_cfg = 4'(lat);
    step();
    chk("start_busy", 32'(busy), 1);
    chk("start_ack", 32'(ack), 0);
    lat_cfg = 4'(lat) ^ 4'hF;
    for (int i = 0; i < lat; i++) begin
      step();
      chk("wait_ack", 32'(ack), 0);
      chk("wait_err", 32'(err), 0);
    end
    step();
    chk("ack_rise", 32'(ack), 1);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_ack", 32'(ack), 1);
      chk("hold_busy", 32'(busy), 1);
      chk("hold_err", 32'(err), 0);
    end
    req = 1'b0;
    step();
    exp_cnt++;
    chk("drop_ack", 32'(ack), 0);
    chk("drop_busy", 32'(busy), 0);
    chk("drop_err", 32'(err), 0);
    chk("txn_cnt", 32'(txn_cnt), exp_cnt % 256);
    $display("txn lat=%0d hold=%0d txn_cnt=%0d txn_cnt2=%0d", lat, hold, txn_cnt, txn_cnt2);
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    exp_cnt = 0;
    rst     = 1'b1;
    req     = 1'b0;
    lat_cfg = 4'd0;
    step();
    step();
    rst = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_ack", 32'(ack), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_err", 32'(err), 0);
      chk("idle_cnt", 32'(txn_cnt), 0);
    end

    // lat=3 with req held 200ns after ack.
    run_txn(3, 20);

    // Three back-to-back L=0 handshakes, req high for 5 sampled edges each.
    for (int k = 0; k < 3; k++) run_txn(0, 3);
    chk("b2b_cnt", 32'(txn_cnt), 4);

    // req dropped after 2 cycles in WAIT with lat=5.
    req     = 1'b1;
    lat_cfg = 4'd5;
    step();
    step();
    chk("abort_busy", 32'(busy), 1);
    req = 1'b0;
    step();
    chk("abort_err", 32'(err), 1);
    chk("abort_ack", 32'(ack), 0);
    chk("abort_busy_low", 32'(busy), 0);
    step();
    chk("abort_err_clr", 32'(err), 0);
    chk("abort_cnt", 32'(txn_cnt), exp_cnt);
    $display("txn abort lat=5 err seen, txn_cnt=%0d", txn_cnt);

    // With lat=0, dropping req at the edge where cnt==0 still gives err, not ack.
    req     = 1'b1;
    lat_cfg = 4'd0;
    step();
    req = 1'b0;
    step();
    chk("abort0_err", 32'(err), 1);
    chk("abort0_ack", 32'(ack), 0);
    step();
    chk("abort0_err_clr", 32'(err), 0);
    $display("txn abort lat=0 err seen, txn_cnt=%0d", txn_cnt);

    run_txn(1, 2);
    run_txn(2, 1);
    run_txn(2, 1);
    chk("pre_rst_cnt", 32'(txn_cnt), 7);

    // Assert reset asynchronously while in ACK.
    req     = 1'b1;
    lat_cfg = 4'd0;
    step();
    step();
    chk("inack_ack", 32'(ack), 1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_ack", 32'(ack), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_err", 32'(err), 0);
    chk("arst_cnt", 32'(txn_cnt), 0);
    req = 1'b0;
    step();
    rst = 1'b0;
    exp_cnt = 0;
    step();
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_ack", 32'(ack), 0);
    $display("txn async reset in ACK, txn_cnt=%0d", txn_cnt);

    // Wrap of the 2-bit counter across five handshakes.
    for (int k = 0; k < 5; k++) begin
      run_txn(lat_tab[k], 1);
      chk("cnt2_wrap", 32'(txn_cnt2), cnt2_tab[k]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
